key_scanner: RTL and testbench

Switch front-end for the piano datapath, sitting directly upstream of `digitalPiano`. It synchronises and debounces the 16 key switches and publishes the stable key mask. It also publishes the highest pressed key as the active note for the tone generator. Every debounced press and release is serialised into a 4-deep event FIFO with a valid/ready handshake, which the SRAM note-recorder drains.

---
 rtl/key_scanner.sv | 136 +++++++++++++
 tb/tb_key_scanner.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scanner.sv
// Key switch front-end: synchronise and debounce 16 switches, publish the stable mask and the
// highest pressed note, and serialise press/release events into a 4-deep FWFT FIFO.
module key_scanner #(
  parameter int unsigned SAMPLE_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] sw,
  output logic [15:0] keysStable,
  output logic        noteValid,
  output logic [3:0]  noteIdx,
  output logic        evValid,
  output logic [3:0]  evKey,
  output logic        evPress,
  input  logic        evReady,
  output logic        overflow
);

  localparam int unsigned DivW = 21;
  localparam logic [DivW-1:0] DivMax = DivW'(SAMPLE_DIV - 1);

  logic [15:0]     sync1_q, sync_q;
  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  logic [15:0]     h0_q, h1_q;
  logic [15:0]     stable_q, stable_d;
  logic [15:0]     pending_q, pending_d;
  logic [15:0]     chg, push_clr;
  logic            note_valid_q, note_valid_d;
  logic [3:0]      note_idx_q, note_idx_d;
  logic            ovf_q, ovf_d;
  logic [4:0]      mem_q [4];
  logic [1:0]      wptr_q, rptr_q;
  logic [2:0]      cnt_q, cnt_d;
  logic            pop, push, push_ok, has_pend;
  logic [3:0]      push_key;

  always_comb begin
    tick  = (div_q == DivMax);
    div_d = tick ? '0 : div_q + 1'b1;
    // A key flips only after three consecutive equal tick samples that differ from its state.
    chg = '0;
    if (tick) begin
      chg = ~(sync_q ^ h0_q) & ~(sync_q ^ h1_q) & (sync_q ^ stable_q);
    end
    stable_d = stable_q ^ chg;
  end

  always_comb begin
    pop      = (cnt_q != 3'd0) && evReady;
    push_ok  = (cnt_q < 3'd4) || pop;
    has_pend = |pending_q;
    push_key = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (pending_q[i]) begin
        push_key = 4'(i);
      end
    end
    push     = has_pend && push_ok;
    push_clr = push ? (16'b1 << push_key) : 16'b0;
    // A change landing on a still-pending key merges into the single queued event.
    ovf_d     = ovf_q | (|(chg & pending_q & ~push_clr));
    pending_d = (pending_q & ~push_clr) | chg;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    note_valid_d = |stable_q;
    note_idx_d   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (stable_q[i]) begin
        note_idx_d = 4'(i);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q      <= '0;
      sync_q       <= '0;
      div_q        <= '0;
      h0_q         <= '0;
      h1_q         <= '0;
      stable_q     <= '0;
      pending_q    <= '0;
      note_valid_q <= 1'b0;
      note_idx_q   <= '0;
      ovf_q        <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sw;
      sync_q       <= sync1_q;
      div_q        <= div_d;
      if (tick) begin
        h0_q <= sync_q;
        h1_q <= h0_q;
      end
      stable_q     <= stable_d;
      pending_q    <= pending_d;
      note_valid_q <= note_valid_d;
      note_idx_q   <= note_idx_d;
      ovf_q        <= ovf_d;
      cnt_q        <= cnt_d;
      if (push) begin
        wptr_q <= wptr_q + 2'd1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 2'd1;
      end
    end
  end

  // Storage needs no reset: the count gates everything read out of it.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wptr_q] <= {stable_q[push_key], push_key};
    end
  end

  always_comb begin
    keysStable = stable_q;
    noteValid  = note_valid_q;
    noteIdx    = note_idx_q;
    overflow   = ovf_q;
    evValid    = (cnt_q != 3'd0);
    evKey      = evValid ? mem_q[rptr_q][3:0] : 4'd0;
    evPress    = evValid ? mem_q[rptr_q][4] : 1'b0;
  end

endmodule

// File: tb/tb_key_scanner.sv
// Self-checking bench for key_scanner: directed scenarios plus randomized switching compared
// against a behavioural run-length debounce / queue model.
module tb_key_scanner;

  localparam int SD = 1;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] sw = '0;
  logic        evReady = 1'b0;
  logic [15:0] keysStable;
  logic        noteValid;
  logic [3:0]  noteIdx;
  logic        evValid;
  logic [3:0]  evKey;
  logic        evPress;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  key_scanner #(.SAMPLE_DIV(SD)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .sw         (sw),
    .keysStable (keysStable),
    .noteValid  (noteValid),
    .noteIdx    (noteIdx),
    .evValid    (evValid),
    .evKey      (evKey),
    .evPress    (evPress),
    .evReady    (evReady),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model: each key remembers its last tick sample and how many ticks in a row it
  // has been seen; three in a row that disagree with the stable state flip the key.
  logic [15:0] m_d1 = '0, m_d2 = '0, m_stable = '0, m_pend = '0, m_last = '0;
  logic [15:0] m_s, m_chg, m_clr;
  logic        m_nv = 1'b0, m_ovf = 1'b0;
  logic [3:0]  m_ni = '0;
  logic [4:0]  m_q[$];
  int          m_run[16];
  int          m_cyc = 0;
  int          m_sz, m_k;
  bit          m_tick, m_pop;

  task automatic model_step();
    if (!RST_N) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_pend = '0; m_last = '0;
      m_nv = 1'b0; m_ni = '0; m_ovf = 1'b0; m_cyc = 0;
      m_q.delete();
      for (int i = 0; i < 16; i++) m_run[i] = 2;
    end else begin
      m_s    = m_d2;
      m_tick = ((m_cyc % SD) == SD - 1);
      m_nv   = |m_stable;
      m_ni   = '0;
      for (int i = 0; i < 16; i++) if (m_stable[i]) m_ni = 4'(i);
      m_sz  = m_q.size();
      m_pop = (m_sz > 0) && evReady;
      if (m_pop) void'(m_q.pop_front());
      m_clr = '0;
      if (m_pend != 0 && (m_sz < 4 || m_pop)) begin
        m_k = 0;
        for (int i = 15; i >= 0; i--) if (m_pend[i]) m_k = i;
        m_q.push_back({m_stable[m_k], 4'(m_k)});
        m_clr[m_k] = 1'b1;
      end
      m_chg = '0;
      if (m_tick) begin
        for (int i = 0; i < 16; i++) begin
          if (m_s[i] == m_last[i]) begin
            if (m_run[i] < 3) m_run[i]++;
          end else begin
            m_last[i] = m_s[i];
            m_run[i]  = 1;
          end
          if (m_run[i] == 3 && m_last[i] != m_stable[i]) m_chg[i] = 1'b1;
        end
      end
      m_ovf    = m_ovf | (|(m_chg & m_pend & ~m_clr));
      m_pend   = (m_pend & ~m_clr) | m_chg;
      m_stable = m_stable ^ m_chg;
      m_d2     = m_d1;
      m_d1     = sw;
      m_cyc++;
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_run[i] = 2;
    forever begin
      @(posedge CLK);
      model_step();
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0; sw = '0; evReady = 1'b0;
    repeat (3) step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({keysStable, noteValid, noteIdx, evValid, evKey, evPress, overflow} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0",
               {keysStable, noteValid, noteIdx, evValid, evKey, evPress, overflow});
    end
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({keysStable, noteValid, noteIdx, evValid, evKey, evPress, overflow} !== 28'd0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %h want 0", c,
                 {keysStable, noteValid, noteIdx, evValid, evKey, evPress, overflow});
      end
    end
  endtask

  task automatic test_single_key();
    logic [15:0] eks;
    do_reset();
    repeat (4) step();
    sw = 16'h8000;
    for (int e = 0; e < 7; e++) begin
      step();
      eks = (e >= 4) ? 16'h8000 : 16'h0000;
      checks++;
      if (keysStable !== eks || noteValid !== (e >= 5) || evValid !== (e >= 5)) begin
        errors++;
        $display("FAIL press_timing edge %0d got ks=%h nv=%b ev=%b want ks=%h nv=%b ev=%b", e,
                 keysStable, noteValid, evValid, eks, e >= 5, e >= 5);
      end
    end
    checks++;
    if (noteIdx !== 4'd15 || evKey !== 4'd15 || evPress !== 1'b1) begin
      errors++;
      $display("FAIL press_event got idx=%0d key=%0d press=%b want 15 15 1",
               noteIdx, evKey, evPress);
    end
    evReady = 1'b1;
    step();
    evReady = 1'b0;
    checks++;
    if (evValid !== 1'b0) begin
      errors++;
      $display("FAIL press_pop got evValid=%b want 0", evValid);
    end
    sw = 16'h0000;
    for (int e = 0; e < 7; e++) begin
      step();
      eks = (e >= 4) ? 16'h0000 : 16'h8000;
      checks++;
      if (keysStable !== eks || noteValid !== (e < 5) || evValid !== (e >= 5)) begin
        errors++;
        $display("FAIL release_timing edge %0d got ks=%h nv=%b ev=%b want ks=%h nv=%b ev=%b", e,
                 keysStable, noteValid, evValid, eks, e < 5, e >= 5);
      end
    end
    checks++;
    if (noteIdx !== 4'd0 || evKey !== 4'd15 || evPress !== 1'b0) begin
      errors++;
      $display("FAIL release_event got idx=%0d key=%0d press=%b want 0 15 0",
               noteIdx, evKey, evPress);
    end
    evReady = 1'b1;
    step();
    evReady = 1'b0;
  endtask

  task automatic test_ripple();
    logic [4:0] got[$];
    do_reset();
    evReady = 1'b1;
    for (int j = 0; j < 16; j++) begin
      sw = 16'hFFFF << (15 - j);
      for (int c = 0; c < 20; c++) begin
        step();
        if (evValid) got.push_back({evPress, evKey});
      end
      checks++;
      if (noteIdx !== 4'd15 || noteValid !== 1'b1 || overflow !== 1'b0) begin
        errors++;
        $display("FAIL ripple_note step %0d got idx=%0d nv=%b ovf=%b want 15 1 0",
                 j, noteIdx, noteValid, overflow);
      end
    end
    checks++;
    if (got.size() != 16) begin
      errors++;
      $display("FAIL ripple_count got %0d want 16", got.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got[i] !== {1'b1, 4'(15 - i)}) begin
          errors++;
          $display("FAIL ripple_event %0d got %h want %h", i, got[i], {1'b1, 4'(15 - i)});
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    repeat (4) step();
    sw = 16'h00FF;
    repeat (15) step();
    checks++;
    if (evValid !== 1'b1 || evKey !== 4'd0 || keysStable !== 16'h00FF) begin
      errors++;
      $display("FAIL full_head got ev=%b key=%0d ks=%h want 1 0 00ff", evValid, evKey, keysStable);
    end
    evReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (evValid !== 1'b1 || evKey !== 4'(i) || evPress !== 1'b1) begin
        errors++;
        $display("FAIL full_drain %0d got ev=%b key=%0d press=%b want 1 %0d 1",
                 i, evValid, evKey, evPress, i);
      end
      step();
    end
    checks++;
    if (evValid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_tail got ev=%b ovf=%b want 0 0", evValid, overflow);
    end
    evReady = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (4) step();
    sw = 16'h0008;
    repeat (2) step();
    sw = 16'h0000;
    for (int c = 0; c < 15; c++) begin
      step();
      checks++;
      if (keysStable !== 16'h0000 || evValid !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc %0d got ks=%h ev=%b want 0000 0", c, keysStable, evValid);
      end
    end
  endtask

  task automatic test_coalesce();
    logic [4:0] got[$];
    logic [4:0] exp[5];
    exp = '{5'h10, 5'h11, 5'h12, 5'h13, 5'h09};
    do_reset();
    repeat (4) step();
    sw = 16'h000F;
    repeat (12) step();
    sw = 16'h020F;
    repeat (10) step();
    sw = 16'h000F;
    repeat (10) step();
    checks++;
    if (overflow !== 1'b1 || keysStable !== 16'h000F) begin
      errors++;
      $display("FAIL coalesce_flag got ovf=%b ks=%h want 1 000f", overflow, keysStable);
    end
    evReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (evValid) got.push_back({evPress, evKey});
      step();
    end
    checks++;
    if (got.size() != 5) begin
      errors++;
      $display("FAIL coalesce_count got %0d want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got[i] !== exp[i]) begin
          errors++;
          $display("FAIL coalesce_event %0d got %h want %h", i, got[i], exp[i]);
        end
      end
    end
    evReady = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    repeat (4) step();
    sw = 16'h0007;
    repeat (12) step();
    checks++;
    if (evValid !== 1'b1) begin
      errors++;
      $display("FAIL midstream_queued got ev=%b want 1", evValid);
    end
    RST_N = 1'b0;
    sw    = 16'h0000;
    step();
    checks++;
    if ({keysStable, noteValid, noteIdx, evValid, evKey, evPress, overflow} !== 28'd0) begin
      errors++;
      $display("FAIL midstream_reset got %h want 0",
               {keysStable, noteValid, noteIdx, evValid, evKey, evPress, overflow});
    end
    RST_N   = 1'b1;
    evReady = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (evValid !== 1'b0) begin
        errors++;
        $display("FAIL midstream_stale cyc %0d got ev=%b want 0", c, evValid);
      end
    end
    evReady = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0]  hd;
    logic [27:0] exp_v, got_v;
    int          idx;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      step();
      hd    = (m_q.size() > 0) ? m_q[0] : 5'd0;
      exp_v = {m_stable, m_nv, m_ni, m_q.size() > 0, hd[3:0], hd[4], m_ovf};
      got_v = {keysStable, noteValid, noteIdx, evValid, evKey, evPress, overflow};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d got %h want %h", c, got_v, exp_v);
      end
      if ($urandom_range(0, 4) == 0) begin
        idx     = $urandom_range(0, 15);
        sw[idx] = ~sw[idx];
      end
      unique case ((c / 150) % 3)
        0:       evReady = ($urandom_range(0, 2) != 0);
        1:       evReady = 1'b0;
        default: evReady = 1'b1;
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_ripple();
    test_fifo_full();
    test_glitch();
    test_coalesce();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
